inv_sub_bytes: RTL and testbench
================================

// Module: inv_sub_bytes
// PURPOSE
//  Inverse SubBytes stage of the AES-128 decryption datapath. Sits between inverse ShiftRows and AddRoundKey.
//  Applies the inverse S-box to all 16 bytes of a 128-bit state.
//  Default build substitutes one 32-bit column per cycle (4 inverse S-boxes) under a valid/ready handshake.
//  The area/latency trade-off is selected at compile time (see CONFIGURATION).
// PARAMETERS
//  DATA_W  128  state width in bits; only 128 is supported
//  COLS    4    columns per state; only 4 is supported; column c = bits [32c+31:32c]
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    state_isr carries a block to accept
//  in_ready   out  1    block can accept; high only in IDLE
//  state_isr  in   128  input state from inverse ShiftRows
//  out_valid  out  1    state_isb holds a finished block
//  out_ready  in   1    downstream accepts state_isb
//  state_isb  out  128  inverse-substituted state (registered)
//  busy       out  1    high in PROC or DONE
// BEHAVIOUR
//  Reset (rst=1 at a posedge):
//   - fsm=IDLE, col_cnt=0, work register=0.
//   - Hence out_valid=0, state_isb=0, busy=0, in_ready=1.
//  FSM states IDLE -> PROC -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture state_isr into work, set col_cnt=0, go to PROC.
//   - PROC, per cycle: work[32*col_cnt +: 32] <= inv_sbox applied to each of its 4 bytes, in place; col_cnt++.
//   - PROC exit: when col_cnt==3 at the edge, col_cnt wraps to 0 and fsm goes to DONE.
//   - DONE: out_valid=1, state_isb=work. Hold both stable while out_ready=0.
//   - DONE exit: on out_ready=1, go to IDLE.
//  Latency and throughput:
//   - Accept edge N gives out_valid=1 after edge N+4.
//   - With out_ready tied high, the minimum issue interval is 6 cycles.
//  Handshake rules:
//   - in_valid while not IDLE is ignored; no buffering.
//   - state_isr is sampled only on the accept edge; later changes to it have no effect.
//   - out_ready outside DONE is ignored.
//  Byte mapping:
//   - Every byte b is replaced by InvSbox[b] (FIPS-197 table).
//   - The function is total: all 256 inputs are defined, no default/X path.
//  Reset mid-operation: rst in PROC or DONE abandons the block. No out_valid follows; state returns to reset values.
//  Simultaneous rst and in_valid: rst wins; nothing is captured.
// CONFIGURATION
//  Macro INV_SB_PARALLEL_EN selects the datapath width.
//  Defined:
//   - 16 inverse S-box instances; PROC lasts exactly 1 cycle and substitutes all 16 bytes.
//   - col_cnt is removed.
//   - Accept edge N gives out_valid after edge N+1; minimum issue interval is 3 cycles.
//  Undefined:
//   - 4 instances, 4-cycle PROC, as described above.
//  Ports and handshake are identical in both builds.
// STRUCTURE
//  aes_pkg (shared):
//   - AES_BLOCK_W=128 and AES_COLS=4.
//   - Constant INV_SBOX table, 256 x 8.
//   - FSM state encoding isb_state_t {IDLE, PROC, DONE}.
//  Sub-module inv_sbox: 8-bit combinational lookup from aes_pkg, instantiated 4x or 16x.
//  The forward sub_bytes table is not shared with this block; it stays separate.
// TESTING
//  T1: state_isr=128'h6363...63, accept -> after 4 cycles out_valid=1, state_isb=128'h0.
//  T2: state_isr=128'h1616...16 -> all bytes 0xFF.
//      byte0=0x7C, byte1=0x00, rest 0x63 -> byte0=0x01, byte1=0x52, rest 0x00.
//  T3: 200 random blocks through sub_bytes then inv_sub_bytes -> output equals original plaintext.
//  T4: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_isb stable, in_ready=0.
//      Pulse in_valid meanwhile -> ignored. Raise out_ready -> IDLE on the next cycle.
//  T5: rst=1 on the 2nd PROC cycle -> next cycle in_ready=1, busy=0, state_isb=0; no out_valid for 10 cycles.
//  T6: rerun T1-T5 with INV_SB_PARALLEL_EN defined -> same data, out_valid one edge after accept.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: block geometry, the FIPS-197 inverse S-box table and the
// inverse SubBytes FSM encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_COLS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } isb_state_t;

    // Row-major: entry 16*r + c is InvSbox[{r,c}]
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box: pure combinational lookup, defined for all 256 inputs.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sub_bytes.sv
// AES inverse SubBytes stage with valid/ready handshake. Default build substitutes one
// column per cycle; define INV_SB_PARALLEL_EN to substitute all 16 bytes in one cycle.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W,
    parameter int COLS   = AES_COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] state_isr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] state_isb,
    output logic              busy
);

    isb_state_t        state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;

`ifdef INV_SB_PARALLEL_EN
    logic [DATA_W-1:0] sub_all;

    for (genvar gi = 0; gi < COLS * 4; gi++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (work_q[8*gi +: 8]),
            .out_byte (sub_all[8*gi +: 8])
        );
    end
`else
    logic [1:0]  col_cnt_q, col_cnt_d;
    logic [31:0] col_in, col_sub;

    // Only the column addressed by col_cnt is routed through the four S-boxes
    assign col_in = work_q[{col_cnt_q, 5'b0} +: 32];

    for (genvar gi = 0; gi < COLS; gi++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (col_in[8*gi +: 8]),
            .out_byte (col_sub[8*gi +: 8])
        );
    end
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
`ifndef INV_SB_PARALLEL_EN
        col_cnt_d = col_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = state_isr;
                    state_d = PROC;
`ifndef INV_SB_PARALLEL_EN
                    col_cnt_d = 2'd0;
`endif
                end
            end
            PROC: begin
`ifdef INV_SB_PARALLEL_EN
                work_d  = sub_all;
                state_d = DONE;
`else
                work_d[{col_cnt_q, 5'b0} +: 32] = col_sub;
                col_cnt_d = col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
`ifndef INV_SB_PARALLEL_EN
            col_cnt_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
`ifndef INV_SB_PARALLEL_EN
            col_cnt_q <= col_cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign state_isb = work_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes; forward S-box is derived from GF(2^8) arithmetic.
// Expected latency follows INV_SB_PARALLEL_EN.
module tb_inv_sub_bytes;

`ifdef INV_SB_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_isr;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_isb;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] fwd_sbox [0:255];

    inv_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_isr (state_isr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_isb (state_isb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present din from a negedge, wait for out_valid and optionally drain it
    task automatic run_block(input logic [127:0] din, input bit drain,
                             output logic [127:0] dout, output int lat);
        in_valid  = 1'b1;
        state_isr = din;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        state_isr = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = state_isb;
        if (drain) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] dout, p, din, held;
        int lat;
        bit ok;

        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (i != 0 && gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            end
            fwd_sbox[i] = affine(inv);
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_isr = '0;
        @(negedge clk); @(negedge clk);
        check("reset_flags", {124'h0, out_valid, busy, in_ready, 1'b0}, {124'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        check("reset_state_isb", state_isb, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // T1
        run_block({16{8'h63}}, 1'b1, dout, lat);
        $display("[TB] T1 in=%h out=%h lat=%0d", {16{8'h63}}, dout, lat);
        check("t1_latency", 128'(lat), 128'(LAT));
        check("t1_data", dout, 128'h0);
        check("t1_back_idle", {126'h0, in_ready, busy}, {126'h0, 1'b1, 1'b0});

        // T2 directed vectors
        run_block({16{8'h16}}, 1'b1, dout, lat);
        $display("[TB] T2a out=%h", dout);
        check("t2_all16", dout, {16{8'hff}});
        run_block({{14{8'h63}}, 8'h00, 8'h7c}, 1'b1, dout, lat);
        $display("[TB] T2b out=%h", dout);
        check("t2_byte01", dout, {112'h0, 8'h52, 8'h01});
        run_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, dout, lat);
        $display("[TB] T2c out=%h", dout);
        check("t2_ramp", dout, 128'hfbd7f3819ea340bf38a53630d56a0952);
        run_block({16{8'hff}}, 1'b1, dout, lat);
        $display("[TB] T2d out=%h", dout);
        check("t2_allff", dout, {16{8'h7d}});
        check("t2_latency", 128'(lat), 128'(LAT));

        // T3 round trip through the forward S-box
        for (int n = 0; n < 200; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            for (int b = 0; b < 16; b++) din[8*b +: 8] = fwd_sbox[p[8*b +: 8]];
            run_block(din, 1'b1, dout, lat);
            $display("[TB] T3 #%0d pt=%h out=%h", n, p, dout);
            check("t3_roundtrip", dout, p);
        end

        // T4 backpressure in DONE, in_valid pulse ignored
        run_block(128'h0f0e0d0c0b0a09080706050403020100, 1'b0, held, lat);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c == 3);
            state_isr = {16{8'h63}};
            @(negedge clk);
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && state_isb === held)) ok = 1'b0;
        end
        in_valid = 1'b0;
        $display("[TB] T4 held=%h stable=%0d", held, ok);
        check("t4_held_value", held, 128'hfbd7f3819ea340bf38a53630d56a0952);
        check("t4_stable", 128'(ok), 128'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_release", {125'h0, out_valid, in_ready, busy}, {125'h0, 1'b0, 1'b1, 1'b0});

        // T5 reset on the second PROC cycle
        in_valid  = 1'b1;
        state_isr = {16{8'h16}};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] T5 after reset in_ready=%0d busy=%0d isb=%h", in_ready, busy, state_isb);
        check("t5_flags", {126'h0, in_ready, busy}, {126'h0, 1'b1, 1'b0});
        check("t5_state_isb", state_isb, 128'h0);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        check("t5_no_out_valid", 128'(ok), 128'd1);

        // rst and in_valid together: nothing captured
        rst = 1'b1; in_valid = 1'b1; state_isr = {16{8'h16}};
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        $display("[TB] rst+in_valid busy=%0d isb=%h", busy, state_isb);
        check("rst_wins", {busy, state_isb}, {1'b0, 128'h0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
